// File: rtl/cpu_controller.sv
// Multi-cycle control unit for the 16-bit datapath: sequences fetch, decode, execute,
// memory and writeback from a latched opcode, with a ready-stalled memory handshake.
module cpu_controller #(
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        mem_ready,
  input  logic        zero_flag,
  output logic        pc_reset,
  output logic        reg_reset,
  output logic        flag_reset,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_we,
  output logic [2:0]  alu_op,
  output logic        flag_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        halted,
  output logic [15:0] retired
);

  localparam int unsigned CntW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam logic [3:0] OpAdd  = 4'h1;
  localparam logic [3:0] OpSub  = 4'h2;
  localparam logic [3:0] OpAnd  = 4'h3;
  localparam logic [3:0] OpOr   = 4'h4;
  localparam logic [3:0] OpLdi  = 4'h5;
  localparam logic [3:0] OpLd   = 4'h6;
  localparam logic [3:0] OpSt   = 4'h7;
  localparam logic [3:0] OpJmp  = 4'h8;
  localparam logic [3:0] OpBeq  = 4'h9;
  localparam logic [3:0] OpHalt = 4'hA;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluAnd  = 3'd2;
  localparam logic [2:0] AluOr   = 3'd3;
  localparam logic [2:0] AluPass = 3'd4;

  typedef enum logic [2:0] {
    StInit,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StHalted
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        opcode_q;
  logic [CntW-1:0]   init_cnt_q;
  logic [15:0]       retired_q;
  logic              init_done;
  logic              retire;
  logic              unused_instr;

  // Only the opcode field is consumed here; the operand fields go straight to the datapath IR.
  assign unused_instr = ^instr[11:0];
  assign init_done    = (init_cnt_q == CntW'(INIT_CYCLES - 1));
  assign retired      = retired_q;

  always_comb begin
    state_d    = state_q;
    pc_reset   = 1'b0;
    reg_reset  = 1'b0;
    flag_reset = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_we     = 1'b0;
    alu_op     = AluAdd;
    flag_we    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      StInit: begin
        pc_reset   = 1'b1;
        reg_reset  = 1'b1;
        flag_reset = 1'b1;
        if (init_done) state_d = StFetch;
      end
      StFetch: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: state_d = StExecute;
      StExecute: begin
        state_d = StFetch;
        case (opcode_q)
          OpAdd: begin alu_op = AluAdd; reg_we = 1'b1; flag_we = 1'b1; end
          OpSub: begin alu_op = AluSub; reg_we = 1'b1; flag_we = 1'b1; end
          OpAnd: begin alu_op = AluAnd; reg_we = 1'b1; flag_we = 1'b1; end
          OpOr:  begin alu_op = AluOr;  reg_we = 1'b1; flag_we = 1'b1; end
          OpLdi: begin alu_op = AluPass; reg_we = 1'b1; end
          OpLd, OpSt: state_d = StMem;
          OpJmp:  pc_load = 1'b1;
          OpBeq:  pc_load = zero_flag;
          OpHalt: state_d = StHalted;
          default: ;
        endcase
      end
      StMem: begin
        // Only LD and ST reach this state.
        if (opcode_q == OpLd) mem_re = 1'b1;
        else                  mem_we = 1'b1;
        if (mem_ready) state_d = (opcode_q == OpLd) ? StWriteback : StFetch;
      end
      StWriteback: begin
        reg_we  = 1'b1;
        alu_op  = AluPass;
        state_d = StFetch;
      end
      StHalted: halted = 1'b1;
      default:  state_d = StInit;
    endcase
  end

  assign retire = (state_d == StFetch || state_d == StHalted) &&
                  (state_q == StExecute || state_q == StMem || state_q == StWriteback);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StInit;
      opcode_q   <= 4'h0;
      init_cnt_q <= '0;
      retired_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (ir_load) opcode_q <= instr[15:12];
      if (state_q == StInit && !init_done) init_cnt_q <= init_cnt_q + CntW'(1);
      if (retire) retired_q <= retired_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks every opcode class, memory stalls, halt and
// reset during a pending store, comparing strobes against hand-derived patterns.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        mem_ready;
  logic        zero_flag;
  logic        pc_reset, reg_reset, flag_reset, ir_load, pc_inc, pc_load;
  logic        reg_we, flag_we, mem_re, mem_we, halted;
  logic [2:0]  alu_op;
  logic [15:0] retired;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Pattern: {pc_reset,reg_reset,flag_reset, ir_load,pc_inc, pc_load,reg_we,flag_we,
  //           mem_re,mem_we, halted, alu_op}
  localparam logic [13:0] O_INIT  = 14'b111_00_000_00_0_000;
  localparam logic [13:0] O_FWAIT = 14'b000_00_000_10_0_000;
  localparam logic [13:0] O_FHIT  = 14'b000_11_000_10_0_000;
  localparam logic [13:0] O_IDLE  = 14'b000_00_000_00_0_000;
  localparam logic [13:0] O_ADD   = 14'b000_00_011_00_0_000;
  localparam logic [13:0] O_SUB   = 14'b000_00_011_00_0_001;
  localparam logic [13:0] O_AND   = 14'b000_00_011_00_0_010;
  localparam logic [13:0] O_OR    = 14'b000_00_011_00_0_011;
  localparam logic [13:0] O_PASS  = 14'b000_00_010_00_0_100;
  localparam logic [13:0] O_JMP   = 14'b000_00_100_00_0_000;
  localparam logic [13:0] O_LDW   = 14'b000_00_000_10_0_000;
  localparam logic [13:0] O_STW   = 14'b000_00_000_01_0_000;
  localparam logic [13:0] O_HALT  = 14'b000_00_000_00_1_000;

  cpu_controller #(.INIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .mem_ready  (mem_ready),
    .zero_flag  (zero_flag),
    .pc_reset   (pc_reset),
    .reg_reset  (reg_reset),
    .flag_reset (flag_reset),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .reg_we     (reg_we),
    .alu_op     (alu_op),
    .flag_we    (flag_we),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] outs();
    return {2'b00, pc_reset, reg_reset, flag_reset, ir_load, pc_inc, pc_load, reg_we,
            flag_we, mem_re, mem_we, halted, alu_op};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic [13:0] exp);
    #1;
    check_eq(tag, outs(), {2'b00, exp});
  endtask

  // FETCH with optional wait cycles, then DECODE; leaves the bench at the EXECUTE cycle.
  task automatic fetch_decode(input logic [15:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      expect_outs("fetch_wait", O_FWAIT);
      tick();
    end
    mem_ready = 1'b1;
    instr     = word;
    expect_outs("fetch_hit", O_FHIT);
    tick();
    instr = 16'hFFFF;
    expect_outs("decode", O_IDLE);  // mem_ready=1 here must be ignored
    tick();
  endtask

  task automatic run_simple(input string tag, input logic [15:0] word, input logic zf,
                            input logic [13:0] exp, input logic [15:0] exp_ret);
    fetch_decode(word, 0);
    zero_flag = zf;
    expect_outs(tag, exp);
    tick();
    zero_flag = 1'b0;
    check_eq({tag, "_retired"}, retired, exp_ret);
  endtask

  initial begin
    reset     = 1'b1;
    instr     = 16'h0000;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    #2;
    check_eq("reset_outs", outs(), {2'b00, O_INIT});
    check_eq("reset_retired", retired, 16'h0000);
    tick();
    tick();
    reset = 1'b0;
    expect_outs("init_c1", O_INIT);
    tick();
    expect_outs("init_c2", O_INIT);
    tick();

    // First fetch stalls one cycle before ADD arrives.
    fetch_decode(16'h1234, 1);
    expect_outs("exec_add", O_ADD);
    tick();
    check_eq("add_retired", retired, 16'd1);

    run_simple("exec_sub",  16'h2abc, 1'b0, O_SUB,  16'd2);
    run_simple("exec_and",  16'h3000, 1'b0, O_AND,  16'd3);
    run_simple("exec_or",   16'h4000, 1'b0, O_OR,   16'd4);
    run_simple("exec_ldi",  16'h5055, 1'b0, O_PASS, 16'd5);
    run_simple("exec_nop",  16'h0000, 1'b1, O_IDLE, 16'd6);
    run_simple("exec_opF",  16'hF000, 1'b1, O_IDLE, 16'd7);
    run_simple("exec_jmp",  16'h8123, 1'b0, O_JMP,  16'd8);
    run_simple("beq_z0",    16'h9010, 1'b0, O_IDLE, 16'd9);
    run_simple("beq_z1",    16'h9010, 1'b1, O_JMP,  16'd10);

    // LD with three wait cycles in MEM: 1+1+1+4+1 = 8 cycles.
    fetch_decode(16'h6001, 0);
    mem_ready = 1'b1;
    expect_outs("exec_ld", O_IDLE);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      expect_outs("ld_wait", O_LDW);
      tick();
    end
    mem_ready = 1'b1;
    expect_outs("ld_ready", O_LDW);
    tick();
    mem_ready = 1'b0;
    expect_outs("ld_wb", O_PASS);
    check_eq("ld_wb_retired", retired, 16'd10);
    tick();
    check_eq("ld_retired", retired, 16'd11);

    // ST with no stall.
    fetch_decode(16'h7002, 0);
    expect_outs("exec_st", O_IDLE);
    tick();
    mem_ready = 1'b1;
    expect_outs("st_ready", O_STW);
    tick();
    check_eq("st_retired", retired, 16'd12);

    // ST stalled, then reset mid-access.
    fetch_decode(16'h7003, 0);
    expect_outs("exec_st2", O_IDLE);
    tick();
    mem_ready = 1'b0;
    expect_outs("st_wait1", O_STW);
    tick();
    expect_outs("st_wait2", O_STW);
    reset = 1'b1;
    #1;
    check_eq("midreset_outs", outs(), {2'b00, O_INIT});
    check_eq("midreset_retired", retired, 16'h0000);
    tick();
    reset = 1'b0;
    expect_outs("reinit_c1", O_INIT);
    tick();
    expect_outs("reinit_c2", O_INIT);
    tick();

    // HALT, then stay halted whatever mem_ready does.
    fetch_decode(16'hA000, 0);
    expect_outs("exec_halt", O_IDLE);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      expect_outs("halted", O_HALT);
      check_eq("halt_retired", retired, 16'd1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle control unit that sequences the 16-bit processor datapath through fetch, decode, execute, memory and writeback. Drives the datapath's pc_reset, reg_reset and flag_reset strobes, register/PC/IR enables, ALU op select and memory handshake from a latched opcode. Sits beside the datapath in the processor top level. Memory access stalls on a ready handshake.

## Interface
- INIT_CYCLES, 2: cycles the reset strobes stay asserted after reset deasserts (≥1).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; single clock domain.
- instr  input  16  instruction word from memory, valid when mem_ready=1 in FETCH.
- mem_ready  input  1  memory completes the current mem_re/mem_we access this cycle.
- zero_flag  input  1  datapath Z flag.
- pc_reset, reg_reset, flag_reset  output  1 each  datapath clears.
- ir_load  output  1  capture instr into datapath IR.
- pc_inc  output  1  PC ← PC+1.
- pc_load  output  1  PC ← IR[11:0] target.
- reg_we  output  1  register file write.
- alu_op  output  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS_IMM.
- flag_we  output  1  update flags from ALU.
- mem_re, mem_we  output  1 each  memory read/write request.
- halted  output  1  processor stopped.
- retired  output  16  instructions-retired count.

## Operation
- States: INIT, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
- Opcode = instr[15:12], latched internally on ir_load. 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 LDI, 6 LD, 7 ST, 8 JMP, 9 BEQ, A HALT. B–F are executed as NOP.
- INIT: pc_reset=reg_reset=flag_reset=1. Stays INIT_CYCLES cycles after reset falls, then FETCH.
- FETCH: mem_re=1 while waiting. On mem_ready=1, ir_load=1 and pc_inc=1 in the same cycle, then DECODE.
- DECODE: one cycle, no strobes, then EXECUTE.
- EXECUTE, by opcode:
  - ADD/SUB/AND/OR: alu_op per table, reg_we=1, flag_we=1, then FETCH.
  - LDI: alu_op=4, reg_we=1, no flag_we, then FETCH.
  - LD/ST: no strobes, then MEM.
  - JMP: pc_load=1, then FETCH.
  - BEQ: pc_load=zero_flag, then FETCH.
  - NOP: FETCH.
  - HALT: HALTED.
- MEM: LD holds mem_re=1 and ST holds mem_we=1 until mem_ready=1. LD then goes to WRITEBACK; ST goes to FETCH.
- WRITEBACK: reg_we=1, alu_op=4, then FETCH.
- HALTED: halted=1, all other strobes 0; leave only by reset.
- retired increments by 1 on every transition into FETCH from EXECUTE, MEM (ST) or WRITEBACK, and on entry to HALTED. It wraps 0xFFFF→0x0000.
- mem_re and mem_we are never asserted together. alu_op is 0 whenever not used.

## Timing
- All outputs are Moore, decoded from state register and latched opcode; no input-to-output combinational path except BEQ's pc_load←zero_flag and FETCH's ir_load/pc_inc←mem_ready.
- Reset values (asynchronous, immediate): state INIT, pc_reset=reg_reset=flag_reset=1, every other output 0, retired=0, latched opcode 0.
- Minimum latencies with mem_ready tied 1: ALU/LDI/JMP/BEQ/NOP 3 cycles; ST 4 cycles; LD 5 cycles. Each mem_ready wait cycle adds one.
- Handshake: a request stays asserted and unchanged until the cycle mem_ready=1 is sampled high; it drops the following cycle. mem_ready outside FETCH/MEM is ignored.
- Reset mid-access drops mem_re/mem_we immediately; the pending access is abandoned and retired is not incremented.

## Test plan
- Reset release with INIT_CYCLES=2 → reset strobes high for exactly 2 clocks after reset falls, then mem_re=1 on the next cycle.
- Program ADD (0x1xxx), mem_ready=1 → ir_load/pc_inc in cycle 1, alu_op=0 with reg_we and flag_we in cycle 3, retired=1.
- LD with mem_ready delayed 3 cycles in MEM → mem_re held 4 cycles, reg_we one cycle later, total 8 cycles, retired=1.
- BEQ with zero_flag=0 then 1 → pc_load 0 then 1 in EXECUTE; JMP always pc_load=1.
- HALT (0xA000) → halted=1 forever and retired frozen; opcode 0xF000 → behaves as NOP.
- Assert reset during ST wait → mem_we drops immediately, outputs at reset values, retired=0.
